// File: rtl/fifo_rst_ctrl.sv
// Reset sequencing controller for the asynchronous FIFO subsystem.
// Synchronizes board reset release, holds FIFO and client core in reset,
// handshakes with the peer domain, then releases FIFO first and core later.
module fifo_rst_ctrl #(
    parameter int HOLD_CYCLES  = 16,
    parameter int GAP_CYCLES   = 4,
    parameter int PEER_TIMEOUT = 1024,
    parameter int CNT_W        = $clog2(
        (HOLD_CYCLES > GAP_CYCLES)
            ? ((HOLD_CYCLES > PEER_TIMEOUT) ? HOLD_CYCLES : PEER_TIMEOUT)
            : ((GAP_CYCLES  > PEER_TIMEOUT) ? GAP_CYCLES  : PEER_TIMEOUT)) + 1
) (
    input  logic clk_sync,
    input  logic async_rst,
    input  logic soft_rst_req,
    input  logic peer_in_rst,
    output logic fifo_rst_n,
    output logic core_rst_n,
    output logic ready,
    output logic busy,
    output logic timeout_err
);

    typedef enum logic [1:0] {
        S_HOLD      = 2'd0,
        S_WAIT_PEER = 2'd1,
        S_GAP       = 2'd2,
        S_RUN       = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PEER_LAST = CNT_W'(PEER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync1_q;
    logic             sync_q;

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             peer_seen_q, peer_seen_d;
    logic             timeout_err_q, timeout_err_d;
    logic             fifo_rst_n_q, fifo_rst_n_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             ready_q,  ready_d;
    logic             busy_q,   busy_d;

    // Two-flop synchronizer: assert asynchronously, release on clk_sync.
    always_ff @(posedge clk_sync or negedge async_rst) begin
        if (!async_rst) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync1_q <= 1'b1;
            sync_q  <= sync1_q;
        end
    end

    // Next-state, counter, handshake tracking and output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        peer_seen_d   = peer_seen_q |
                        (peer_in_rst && (state_q == S_HOLD || state_q == S_WAIT_PEER));

        case (state_q)
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT_PEER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT_PEER: begin
                if (peer_seen_q && !peer_in_rst) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == PEER_LAST) begin
                    // Peer never completed the handshake; proceed but flag it.
                    timeout_err_d = 1'b1;
                    state_d       = S_GAP;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // Soft restart wins over everything on this edge, including a
        // coincident timeout; the sticky error keeps its previous value.
        if (soft_rst_req) begin
            state_d       = S_HOLD;
            cnt_d         = '0;
            peer_seen_d   = 1'b0;
            timeout_err_d = timeout_err_q;
        end

        // Outputs decode from the next state so they register on the same edge.
        fifo_rst_n_d = (state_d == S_GAP) || (state_d == S_RUN);
        core_rst_n_d = (state_d == S_RUN);
        ready_d      = (state_d == S_RUN);
        busy_d       = (state_d != S_RUN);
    end

    // Sequencer state and registered outputs; held in reset until sync release.
    always_ff @(posedge clk_sync or negedge async_rst) begin
        if (!async_rst) begin
            state_q       <= S_HOLD;
            cnt_q         <= '0;
            peer_seen_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            fifo_rst_n_q  <= 1'b0;
            core_rst_n_q  <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b1;
        end else if (!sync_q) begin
            state_q       <= S_HOLD;
            cnt_q         <= '0;
            peer_seen_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            fifo_rst_n_q  <= 1'b0;
            core_rst_n_q  <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            peer_seen_q   <= peer_seen_d;
            timeout_err_q <= timeout_err_d;
            fifo_rst_n_q  <= fifo_rst_n_d;
            core_rst_n_q  <= core_rst_n_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
        end
    end

    assign fifo_rst_n  = fifo_rst_n_q;
    assign core_rst_n  = core_rst_n_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fifo_rst_ctrl.sv
// Directed bench for fifo_rst_ctrl: default instance for power-on and soft
// restarts, short-timeout instance for timeout and async-reset cases.
module tb_fifo_rst_ctrl;

    logic clk = 1'b0;

    logic rst_a, soft_a, peer_a;
    logic fifo_a, core_a, ready_a, busy_a, terr_a;

    logic rst_b, soft_b, peer_b;
    logic fifo_b, core_b, ready_b, busy_b, terr_b;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_rst_ctrl dut_a (
        .clk_sync     (clk),
        .async_rst    (rst_a),
        .soft_rst_req (soft_a),
        .peer_in_rst  (peer_a),
        .fifo_rst_n   (fifo_a),
        .core_rst_n   (core_a),
        .ready        (ready_a),
        .busy         (busy_a),
        .timeout_err  (terr_a)
    );

    fifo_rst_ctrl #(.PEER_TIMEOUT(8)) dut_b (
        .clk_sync     (clk),
        .async_rst    (rst_b),
        .soft_rst_req (soft_b),
        .peer_in_rst  (peer_b),
        .fifo_rst_n   (fifo_b),
        .core_rst_n   (core_b),
        .ready        (ready_b),
        .busy         (busy_b),
        .timeout_err  (terr_b)
    );

    task automatic chk_val(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%b exp=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1ns past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_a = 1'b0; soft_a = 1'b0; peer_a = 1'b1;
        rst_b = 1'b0; soft_b = 1'b0; peer_b = 1'b0;

        // ---------------- power-on, default parameters ----------------
        step(5);
        chk_val("a_rst_fifo",  fifo_a,  1'b0);
        chk_val("a_rst_core",  core_a,  1'b0);
        chk_val("a_rst_ready", ready_a, 1'b0);
        chk_val("a_rst_busy",  busy_a,  1'b1);
        chk_val("a_rst_terr",  terr_a,  1'b0);
        rst_a = 1'b1;
        step(10);                         // peer in reset for edges 1..10
        peer_a = 1'b0;
        step(8);                          // edge 18
        chk_val("a_e18_fifo", fifo_a, 1'b0);
        step(1);                          // edge 19
        chk_val("a_e19_fifo", fifo_a, 1'b1);
        chk_val("a_e19_core", core_a, 1'b0);
        chk_val("a_e19_busy", busy_a, 1'b1);
        step(3);                          // edge 22
        chk_val("a_e22_core",  core_a,  1'b0);
        chk_val("a_e22_ready", ready_a, 1'b0);
        step(1);                          // edge 23
        chk_val("a_e23_core",  core_a,  1'b1);
        chk_val("a_e23_ready", ready_a, 1'b1);
        chk_val("a_e23_busy",  busy_a,  1'b0);
        chk_val("a_e23_terr",  terr_a,  1'b0);

        // ---------------- soft reset in RUN ----------------
        step(2);
        soft_a = 1'b1;
        step(1);                          // edge S samples the request
        soft_a = 1'b0;
        chk_val("a_soft_fifo",  fifo_a,  1'b0);
        chk_val("a_soft_core",  core_a,  1'b0);
        chk_val("a_soft_ready", ready_a, 1'b0);
        chk_val("a_soft_busy",  busy_a,  1'b1);
        peer_a = 1'b1;
        step(3);                          // S+3
        peer_a = 1'b0;
        step(13);                         // S+16
        chk_val("a_s16_fifo", fifo_a, 1'b0);
        step(1);                          // S+17
        chk_val("a_s17_fifo", fifo_a, 1'b1);
        chk_val("a_s17_core", core_a, 1'b0);
        step(3);                          // S+20
        chk_val("a_s20_ready", ready_a, 1'b0);
        step(1);                          // S+21
        chk_val("a_s21_ready", ready_a, 1'b1);
        chk_val("a_s21_terr",  terr_a,  1'b0);

        // ---------------- soft reset mid-GAP, then held request ----------------
        soft_a = 1'b1;
        step(1);                          // edge S
        soft_a = 1'b0;
        peer_a = 1'b1;
        step(1);                          // S+1
        peer_a = 1'b0;
        step(18);                         // S+19: GAP counter = 2
        chk_val("a_gap_fifo", fifo_a, 1'b1);
        chk_val("a_gap_core", core_a, 1'b0);
        soft_a = 1'b1;
        step(1);                          // S+20
        chk_val("a_gsoft_fifo", fifo_a, 1'b0);
        chk_val("a_gsoft_core", core_a, 1'b0);
        step(2);                          // request held through S+22 = T
        chk_val("a_held_fifo", fifo_a, 1'b0);
        chk_val("a_held_busy", busy_a, 1'b1);
        soft_a = 1'b0;
        peer_a = 1'b1;
        step(1);                          // T+1
        peer_a = 1'b0;
        step(15);                         // T+16
        chk_val("a_t16_fifo", fifo_a, 1'b0);
        step(1);                          // T+17
        chk_val("a_t17_fifo", fifo_a, 1'b1);
        step(4);                          // T+21
        chk_val("a_t21_ready", ready_a, 1'b1);
        chk_val("a_t21_core",  core_a,  1'b1);

        // ---------------- peer never resets, PEER_TIMEOUT=8 ----------------
        peer_b = 1'b0;
        rst_b  = 1'b1;
        step(25);                         // edge 25
        chk_val("b_e25_fifo", fifo_b, 1'b0);
        chk_val("b_e25_terr", terr_b, 1'b0);
        step(1);                          // edge 26
        chk_val("b_e26_fifo", fifo_b, 1'b1);
        chk_val("b_e26_terr", terr_b, 1'b1);
        chk_val("b_e26_core", core_b, 1'b0);
        step(3);                          // edge 29
        chk_val("b_e29_core", core_b, 1'b0);
        step(1);                          // edge 30
        chk_val("b_e30_core",  core_b,  1'b1);
        chk_val("b_e30_ready", ready_b, 1'b1);

        // ---------------- soft restart keeps error, async pulse clears ----------------
        soft_b = 1'b1;
        step(1);
        soft_b = 1'b0;
        chk_val("b_soft_terr", terr_b, 1'b1);
        chk_val("b_soft_fifo", fifo_b, 1'b0);
        step(18);                         // in WAIT_PEER
        chk_val("b_wait_terr", terr_b, 1'b1);
        rst_b = 1'b0;
        #1;
        chk_val("b_arst_terr", terr_b, 1'b0);
        chk_val("b_arst_busy", busy_b, 1'b1);
        chk_val("b_arst_fifo", fifo_b, 1'b0);
        #3;
        rst_b  = 1'b1;                    // next rising edge is sync edge 1
        peer_b = 1'b1;                    // peer stuck in reset from here on

        // ---------------- peer stuck in reset, PEER_TIMEOUT=8 ----------------
        step(25);                         // edge 25
        chk_val("b_stk25_fifo", fifo_b, 1'b0);
        chk_val("b_stk25_terr", terr_b, 1'b0);
        step(1);                          // edge 26
        chk_val("b_stk26_fifo", fifo_b, 1'b1);
        chk_val("b_stk26_terr", terr_b, 1'b1);
        step(3);                          // edge 29
        chk_val("b_stk29_core", core_b, 1'b0);
        step(1);                          // edge 30
        chk_val("b_stk30_core", core_b, 1'b1);
        chk_val("b_stk30_busy", busy_b, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
